pixel_dma_reader: RTL and testbench

Burst-reading memory master that streams a frame of PIXEL_COUNT words from external memory into the input pixel FIFO of the processing chain (greyscale stage). It is the producer side of the FIFO: it issues a new burst only when the FIFO has room for the whole burst. It uses the same start/endf frame handshake as the other pipeline stages.

---
 rtl/pixel_dma_reader_if.sv | 44 ++++
 rtl/pixel_dma_reader.sv | 156 +++++++++++++++
 tb/tb_pixel_dma_reader.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_dma_reader_if.sv
// Memory-master read bus plus pixel FIFO write port used by pixel_dma_reader.
// master: the DMA reader side. slave: memory / FIFO side (or a bench model).
interface pixel_dma_reader_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BURST_LOG2      = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 8
);
  // Memory read channel
  logic [ADDR_WIDTH-1:0]    mm_address;
  logic                     mm_read;
  logic [BURST_LOG2:0]      mm_burstcount;
  logic                     mm_waitrequest;
  logic [DATA_WIDTH-1:0]    mm_readdata;
  logic                     mm_readdatavalid;
  // Pixel FIFO write side
  logic [DATA_WIDTH-1:0]    data_fifo_out;
  logic                     write_fifo_out;
  logic [FIFO_DEPTH_LOG2:0] usedw_fifo_out;

  modport master (
    output mm_address,
    output mm_read,
    output mm_burstcount,
    input  mm_waitrequest,
    input  mm_readdata,
    input  mm_readdatavalid,
    output data_fifo_out,
    output write_fifo_out,
    input  usedw_fifo_out
  );

  modport slave (
    input  mm_address,
    input  mm_read,
    input  mm_burstcount,
    output mm_waitrequest,
    output mm_readdata,
    output mm_readdatavalid,
    input  data_fifo_out,
    input  write_fifo_out,
    output usedw_fifo_out
  );
endinterface

// File: rtl/pixel_dma_reader.sv
// Burst-reading memory master: streams one frame of PIXEL_COUNT words into the
// pixel FIFO, issuing a burst only when the FIFO has room for all of it.
// One burst outstanding at a time; start/endf frame handshake.
module pixel_dma_reader #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH      = 256,
  parameter int unsigned FIFO_DEPTH_LOG2 = 8,
  parameter int unsigned PIXEL_COUNT     = 384000,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned BURST_LOG2      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  output logic                  endf,
  pixel_dma_reader_if.master    bus
);

  localparam int unsigned BcW          = BURST_LOG2 + 1;
  localparam int unsigned BytesPerWord = DATA_WIDTH / 8;
  // Two words of slack: our output register plus the FIFO's usedw lag.
  localparam int unsigned UsedwLimit   = FIFO_DEPTH - BURST_LEN - 2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitData,
    StDone
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_req_left;
  logic [31:0]           r_rx_left;
  logic [31:0]           r_beat_cnt;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_data;

  logic [BcW-1:0]        w_burst_words;
  logic                  w_fifo_room;
  logic                  w_mm_read;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_last_beat;
  logic                  w_frame_done;
  logic                  w_endf;

  // Size of the next burst: a full burst, or whatever is left of the frame.
  always_comb begin
    w_burst_words = BcW'(BURST_LEN);
    if (r_req_left < BURST_LEN) begin
      w_burst_words = BcW'(r_req_left);
    end
  end

  assign w_fifo_room  = (32'(bus.usedw_fifo_out) <= UsedwLimit);
  assign w_accept     = w_mm_read & ~bus.mm_waitrequest;
  assign w_beat       = (r_state == StWaitData) & bus.mm_readdatavalid;
  assign w_last_beat  = w_beat & (r_beat_cnt <= 32'd1);
  assign w_frame_done = (r_req_left == 32'd0) | (r_rx_left <= 32'd1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and FSM-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    w_mm_read    = 1'b0;
    w_endf       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = StReq;
        end
      end
      StReq: begin
        if (w_burst_words == '0) begin
          // Nothing left to fetch; only reachable with a degenerate frame size.
          w_state_next = StDone;
        end else begin
          w_mm_read = w_fifo_room;
          if (w_fifo_room && !bus.mm_waitrequest) begin
            w_state_next = StWaitData;
          end
        end
      end
      StWaitData: begin
        if (w_last_beat) begin
          w_state_next = w_frame_done ? StDone : StReq;
        end
      end
      StDone: begin
        w_endf       = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Address/count bookkeeping and the single registered FIFO write stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_req_left <= '0;
      r_rx_left  <= '0;
      r_beat_cnt <= '0;
      r_wr       <= 1'b0;
      r_data     <= '0;
    end else begin
      r_wr <= w_beat;
      if (w_beat) begin
        r_data <= bus.mm_readdata;
      end

      if ((r_state == StIdle) && start) begin
        r_addr     <= base_address;
        r_req_left <= PIXEL_COUNT;
        r_rx_left  <= PIXEL_COUNT;
      end

      if (w_accept) begin
        r_addr     <= r_addr + ADDR_WIDTH'(w_burst_words) * ADDR_WIDTH'(BytesPerWord);
        r_req_left <= r_req_left - 32'(w_burst_words);
        r_beat_cnt <= 32'(w_burst_words);
      end

      if (w_beat) begin
        if (r_beat_cnt != 32'd0) begin
          r_beat_cnt <= r_beat_cnt - 32'd1;
        end
        if (r_rx_left != 32'd0) begin
          r_rx_left <= r_rx_left - 32'd1;
        end
      end
    end
  end

  assign bus.mm_read        = w_mm_read;
  assign bus.mm_address     = r_addr;
  assign bus.mm_burstcount  = (r_state == StReq) ? w_burst_words : '0;
  assign bus.write_fifo_out = r_wr;
  assign bus.data_fifo_out  = r_data;
  assign endf               = w_endf;

endmodule

// File: tb/tb_pixel_dma_reader.sv
// Bench for pixel_dma_reader: randomized memory slave plus a frame-level
// reference model (burst list and word sequence computed from frame base).
module tb_pixel_dma_reader;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 32;
  localparam int unsigned FD     = 256;
  localparam int unsigned FDL    = 8;
  localparam int unsigned PC     = 40;
  localparam int unsigned BL     = 16;
  localparam int unsigned BLL    = 4;
  localparam int unsigned THRESH = FD - BL - 2;
  localparam int unsigned NB     = (PC + BL - 1) / BL;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_address;
  logic          endf;

  pixel_dma_reader_if #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .BURST_LOG2     (BLL),
    .FIFO_DEPTH_LOG2(FDL)
  ) bus ();

  pixel_dma_reader #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .FIFO_DEPTH     (FD),
    .FIFO_DEPTH_LOG2(FDL),
    .PIXEL_COUNT    (PC),
    .BURST_LEN      (BL),
    .BURST_LOG2     (BLL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_address(base_address),
    .endf        (endf),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a fixed function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'h00, a[23:0] ^ 24'h5a3c96};
  endfunction

  // Words in burst idx of a frame.
  function automatic int exp_len(input int idx);
    int rem;
    rem = int'(PC) - idx * int'(BL);
    if (rem <= 0) return 0;
    return (rem > int'(BL)) ? int'(BL) : rem;
  endfunction

  // Knobs
  logic [AW-1:0] knob_base = '0;
  bit            knob_start = 1'b0;
  bit            knob_spurious = 1'b0;
  int            knob_gap = 0;         // <0: random 0..3
  int            knob_lat = 0;
  int            knob_stall_first = 0;
  int            knob_stall_rand = 0;
  logic [FDL:0]  usedw = '0;

  // Model / slave state
  logic [AW-1:0] frame_base = '0;
  logic [AW-1:0] beat_addr = '0;
  logic [DW-1:0] exp_data = '0;
  bit            busy = 1'b0;
  bit            in_req = 1'b0;
  bit            exp_wr = 1'b0;
  bit            exp_endf = 1'b0;
  bit            last_read = 1'b0;
  int            bursts_acc = 0;
  int            wr_idx = 0;
  int            pending = 0;
  int            gap_cnt = 0;
  int            stall_left = 0;
  int            stall_obs = 0;
  int            wr_cnt = 0;
  int            endf_cnt = 0;
  logic [AW-1:0] acc_addr[$];
  int            acc_len[$];

  // One clock cycle: drive inputs after the edge, sample, then advance model.
  task automatic cycle();
    bit            drv_start;
    bit            drv_valid;
    bit            drv_legit;
    bit            s_read;
    bit            s_wait;
    logic [AW-1:0] e_addr;
    @(posedge clk);
    #1;
    drv_start    = knob_start;
    knob_start   = 1'b0;
    start        = drv_start;
    base_address = knob_base;
    bus.usedw_fifo_out = usedw;
    bus.mm_waitrequest = (stall_left > 0);
    drv_valid = 1'b0;
    drv_legit = 1'b0;
    if (pending > 0) begin
      if (gap_cnt == 0) begin
        drv_valid = 1'b1;
        drv_legit = 1'b1;
        bus.mm_readdata = mem_word(beat_addr);
        beat_addr = beat_addr + 32'd4;
        pending--;
        gap_cnt = (knob_gap < 0) ? int'($urandom_range(3, 0)) : knob_gap;
      end else begin
        gap_cnt--;
      end
    end else if (knob_spurious) begin
      drv_valid = 1'b1;
      bus.mm_readdata = $urandom;
    end
    bus.mm_readdatavalid = drv_valid;
    #1;
    s_read    = bus.mm_read;
    s_wait    = bus.mm_waitrequest;
    last_read = s_read;
    check("write_fifo_out", bus.write_fifo_out, exp_wr);
    if (exp_wr) check("data_fifo_out", bus.data_fifo_out, exp_data);
    check("endf", endf, exp_endf);
    check("mm_read", s_read, in_req && (usedw <= THRESH));
    if (s_read) begin
      e_addr = frame_base + 32'(bursts_acc) * BL * 4;
      check("mm_address", bus.mm_address, e_addr);
      check("mm_burstcount", bus.mm_burstcount, exp_len(bursts_acc));
    end
    if (bus.write_fifo_out) wr_cnt++;
    if (endf) endf_cnt++;
    exp_wr   = drv_legit;
    exp_endf = 1'b0;
    if (drv_legit) begin
      e_addr   = frame_base + 32'(wr_idx) * 4;
      exp_data = mem_word(e_addr);
      wr_idx++;
      if (wr_idx == int'(PC)) begin
        exp_endf = 1'b1;
        busy     = 1'b0;
      end else if (pending == 0) begin
        in_req = 1'b1;
      end
    end
    if (s_read && s_wait) begin
      stall_left--;
      stall_obs++;
    end
    if (s_read && !s_wait) begin
      acc_addr.push_back(bus.mm_address);
      acc_len.push_back(int'(bus.mm_burstcount));
      bursts_acc++;
      pending    = int'(bus.mm_burstcount);
      beat_addr  = bus.mm_address;
      gap_cnt    = int'($urandom_range(knob_lat, 0));
      in_req     = 1'b0;
      stall_left = int'($urandom_range(knob_stall_rand, 0));
    end
    if (drv_start && !busy) begin
      busy       = 1'b1;
      in_req     = 1'b1;
      frame_base = knob_base;
      bursts_acc = 0;
      wr_idx     = 0;
      stall_left = knob_stall_first;
    end
  endtask

  task automatic frame_setup(input logic [AW-1:0] base, input int stall_first, input int gap,
                             input int lat, input int stall_rand);
    knob_base        = base;
    knob_stall_first = stall_first;
    knob_gap         = gap;
    knob_lat         = lat;
    knob_stall_rand  = stall_rand;
    acc_addr.delete();
    acc_len.delete();
    endf_cnt   = 0;
    wr_cnt     = 0;
    stall_obs  = 0;
    knob_start = 1'b1;
  endtask

  task automatic frame_finish(input int mid_start);
    bit mid_done;
    mid_done = 1'b0;
    for (int i = 0; i < 3000 && endf_cnt == 0; i++) begin
      if (mid_start != 0 && !mid_done && pending > 0 && bursts_acc == 2) begin
        knob_base  = 32'h0000_bad0;
        knob_start = 1'b1;
        mid_done   = 1'b1;
      end
      cycle();
    end
    check("frame_endf_seen", endf_cnt, 1);
    check("frame_writes", wr_cnt, PC);
    check("frame_bursts", acc_addr.size(), NB);
    repeat (3) cycle();
    check("frame_endf_once", endf_cnt, 1);
    check("frame_writes_after", wr_cnt, PC);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mm_read"}, bus.mm_read, 0);
    check({tag, "_mm_address"}, bus.mm_address, 0);
    check({tag, "_mm_burstcount"}, bus.mm_burstcount, 0);
    check({tag, "_write"}, bus.write_fifo_out, 0);
    check({tag, "_data"}, bus.data_fifo_out, 0);
    check({tag, "_endf"}, endf, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_address = '0;
    bus.mm_waitrequest   = 1'b0;
    bus.mm_readdata      = '0;
    bus.mm_readdatavalid = 1'b0;
    bus.usedw_fifo_out   = '0;
    #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) cycle();

    // Basic frame: zero-latency slave, empty FIFO.
    frame_setup(32'h0000_1000, 0, 0, 0, 0);
    frame_finish(0);
    if (acc_addr.size() >= 3) begin
      check("t1_b0_addr", acc_addr[0], 32'h1000);
      check("t1_b0_len", acc_len[0], 16);
      check("t1_b1_addr", acc_addr[1], 32'h1040);
      check("t1_b1_len", acc_len[1], 16);
      check("t1_b2_addr", acc_addr[2], 32'h1080);
      check("t1_b2_len", acc_len[2], 8);
    end

    // Five stall cycles on the first request.
    frame_setup(32'h0000_4000, 5, 0, 0, 0);
    frame_finish(0);
    check("t2_stall_cycles", stall_obs, 5);

    // FIFO nearly full: no request at 239, request as soon as it reads 238.
    usedw = 9'd239;
    frame_setup(32'h0000_8000, 0, 0, 0, 0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t3_full_no_read", last_read, 0);
    end
    usedw = 9'd238;
    cycle();
    check("t3_drop_read", last_read, 1);
    frame_finish(0);
    usedw = 9'd0;

    // Three idle cycles between beats.
    frame_setup(32'h0001_0000, 0, 3, 0, 0);
    frame_finish(0);

    // Start during WAIT_DATA is ignored; spurious valid while idle writes nothing.
    frame_setup(32'h0002_0000, 0, 1, 2, 1);
    frame_finish(1);
    knob_spurious = 1'b1;
    repeat (4) cycle();
    knob_spurious = 1'b0;
    check("t5_no_spurious_write", wr_cnt, PC);

    // Reset during the second burst.
    frame_setup(32'h0000_2000, 0, 0, 1, 0);
    for (int i = 0; i < 500 && !(bursts_acc == 2 && pending > 0 && pending <= 12); i++) cycle();
    check("t6_in_second_burst", bursts_acc, 2);
    rst = 1'b1;
    #1;
    check_outputs_zero("t6_rst");
    busy       = 1'b0;
    in_req     = 1'b0;
    exp_wr     = 1'b0;
    exp_endf   = 1'b0;
    stall_left = 0;
    pending    = 0;
    knob_spurious = 1'b1;   // data still in flight from the aborted burst
    repeat (2) cycle();
    rst = 1'b0;
    repeat (3) cycle();
    knob_spurious = 1'b0;
    frame_setup(32'h0000_2000, 0, 0, 0, 0);
    frame_finish(0);
    if (acc_addr.size() >= 1) check("t6_restart_addr", acc_addr[0], 32'h2000);

    // Randomized frames, including an address that wraps.
    for (int f = 0; f < 6; f++) begin
      logic [AW-1:0] b;
      b = (f == 0) ? 32'hffff_ffc0 : {$urandom, 2'b00};
      frame_setup(b, int'($urandom_range(4, 0)), -1, int'($urandom_range(4, 0)),
                  int'($urandom_range(3, 0)));
      frame_finish(int'($urandom_range(1, 0)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
